// File: rtl/if_stage.sv
// Instruction-fetch stage: drives imem requests from the PC, loads IF/ID, skids one entry on ID stalls
// and drains an in-flight response after a flush. Define IF_ALIGN_CHECK_EN for misaligned-PC exceptions.
module if_stage #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  output logic        pc_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        if_id_exc_o
);

  // Handshake: a request (imem_req_o=1) completes on the cycle imem_valid_i=1; until then
  // imem_req_o stays high and imem_addr_o stays constant.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        if_id_exc_q, if_id_exc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_exc_q, skid_exc_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        misalign;
  logic        fetch_done;
  logic [31:0] fetch_instr;

`ifdef IF_ALIGN_CHECK_EN
  assign misalign = (pc_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_exc_d   = if_id_exc_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_exc_d    = skid_exc_q;
    drain_addr_d  = drain_addr_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = pc_i;
    pc_stall_o    = 1'b1;
    fetch_done    = 1'b0;
    fetch_instr   = imem_rdata_i;

    case (state_q)
      S_FETCH: begin
        // A misaligned PC completes immediately without touching memory.
        imem_req_o  = !misalign;
        fetch_done  = misalign || imem_valid_i;
        fetch_instr = misalign ? NOP : imem_rdata_i;
        pc_stall_o  = !(fetch_done || flush_i);
        if (flush_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP;
          if_id_exc_d   = 1'b0;
          if (!fetch_done) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_i;
          end
        end else if (fetch_done) begin
          if (hazard_i) begin
            skid_pc_d    = pc_i;
            skid_instr_d = fetch_instr;
            skid_exc_d   = misalign;
            state_d      = S_HOLD;
          end else begin
            if_id_pc_d    = pc_i;
            if_id_instr_d = fetch_instr;
            if_id_valid_d = 1'b1;
            if_id_exc_d   = misalign;
          end
        end else if (!hazard_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP;
          if_id_exc_d   = 1'b0;
        end
      end

      S_HOLD: begin
        pc_stall_o = !flush_i;
        if (flush_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP;
          if_id_exc_d   = 1'b0;
          state_d       = S_FETCH;
        end else if (!hazard_i) begin
          if_id_pc_d    = skid_pc_q;
          if_id_instr_d = skid_instr_q;
          if_id_valid_d = 1'b1;
          if_id_exc_d   = skid_exc_q;
          state_d       = S_FETCH;
        end
      end

      S_DRAIN: begin
        // Keep the abandoned request alive until memory answers; its data is dropped.
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        pc_stall_o  = !flush_i;
        if (flush_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP;
          if_id_exc_d   = 1'b0;
        end
        if (imem_valid_i) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
      if_id_exc_q   <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= NOP;
      skid_exc_q    <= 1'b0;
      drain_addr_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_exc_q   <= if_id_exc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_exc_q    <= skid_exc_d;
      drain_addr_q  <= drain_addr_d;
    end
  end

  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign if_id_exc_o   = if_id_exc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, reset corner cases, then random traffic
// checked against a program-order model of the instruction stream.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        hazard_i;
  logic        flush_i;
  logic        pc_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        if_id_exc_o;

  if_stage #(.NOP(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .hazard_i      (hazard_i),
    .flush_i       (flush_i),
    .pc_stall_o    (pc_stall_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o),
    .if_id_exc_o   (if_id_exc_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[27:0], 4'h3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        haz;
    logic        fl;
    logic        vld;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] pc, input logic haz, input logic fl, input logic vld,
                     input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic e_valid, input logic e_exc);
    vec_t v;
    v.pc = pc; v.haz = haz; v.fl = fl; v.vld = vld;
    v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_exc = e_exc;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hazard_i = 1'b0; flush_i = 1'b0; imem_valid_i = 1'b0;
    pc_i = 32'h0; imem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ifid_pc"}, if_id_pc_o, 32'h0);
    check({tag, "_ifid_instr"}, if_id_instr_o, NOP);
    check({tag, "_ifid_valid"}, {31'h0, if_id_valid_o}, 32'h0);
    check({tag, "_ifid_exc"}, {31'h0, if_id_exc_o}, 32'h0);
    check({tag, "_req"}, {31'h0, imem_req_o}, 32'h1);
    check({tag, "_stall"}, {31'h0, pc_stall_o}, 32'h1);
  endtask

  // ---------------- random-phase state ----------------
  logic [31:0] target, exp_pc, pre_pc, pre_instr, prev_addr;
  logic        pre_valid, stall_s, fl_s, haz_s, prev_pending, done_mem, consume;
  int          busy, lat, cnt, idle, consumed;

  initial begin
    rst = 1'b1; pc_i = 32'h0; hazard_i = 1'b0; flush_i = 1'b0;
    imem_valid_i = 1'b0; imem_rdata_i = 32'h0;

    // Directed vectors: pc, haz, flush, valid | req, addr, stall | IF/ID pc, instr, valid, exc
    add(32'h000, 0, 0, 1, 1, 32'h000, 0, 32'h000, mem_word(32'h000), 1, 0);
    add(32'h004, 0, 0, 1, 1, 32'h004, 0, 32'h004, mem_word(32'h004), 1, 0);
    add(32'h008, 0, 0, 1, 1, 32'h008, 0, 32'h008, mem_word(32'h008), 1, 0);
    add(32'h040, 0, 0, 0, 1, 32'h040, 1, 32'h008, NOP, 0, 0);
    add(32'h040, 0, 0, 0, 1, 32'h040, 1, 32'h008, NOP, 0, 0);
    add(32'h040, 0, 0, 1, 1, 32'h040, 0, 32'h040, mem_word(32'h040), 1, 0);
    add(32'h00C, 0, 0, 1, 1, 32'h00C, 0, 32'h00C, mem_word(32'h00C), 1, 0);
    add(32'h010, 1, 0, 1, 1, 32'h010, 0, 32'h00C, mem_word(32'h00C), 1, 0);
    add(32'h014, 1, 0, 0, 0, 32'h000, 1, 32'h00C, mem_word(32'h00C), 1, 0);
    add(32'h014, 0, 0, 0, 0, 32'h000, 1, 32'h010, mem_word(32'h010), 1, 0);
    add(32'h014, 0, 0, 1, 1, 32'h014, 0, 32'h014, mem_word(32'h014), 1, 0);
    add(32'h020, 0, 0, 0, 1, 32'h020, 1, 32'h014, NOP, 0, 0);
    add(32'h020, 0, 1, 0, 1, 32'h020, 0, 32'h014, NOP, 0, 0);
    add(32'h100, 0, 0, 0, 1, 32'h020, 1, 32'h014, NOP, 0, 0);
    add(32'h100, 0, 0, 1, 1, 32'h020, 1, 32'h014, NOP, 0, 0);
    add(32'h100, 0, 0, 1, 1, 32'h100, 0, 32'h100, mem_word(32'h100), 1, 0);
    add(32'h104, 1, 0, 1, 1, 32'h104, 0, 32'h100, mem_word(32'h100), 1, 0);
    add(32'h108, 1, 1, 0, 0, 32'h000, 0, 32'h100, NOP, 0, 0);
    add(32'h200, 0, 0, 1, 1, 32'h200, 0, 32'h200, mem_word(32'h200), 1, 0);
    add(32'h204, 0, 1, 1, 1, 32'h204, 0, 32'h200, NOP, 0, 0);
    add(32'h300, 0, 0, 1, 1, 32'h300, 0, 32'h300, mem_word(32'h300), 1, 0);
    add(32'h304, 1, 0, 0, 1, 32'h304, 1, 32'h300, mem_word(32'h300), 1, 0);
    add(32'h304, 0, 0, 1, 1, 32'h304, 0, 32'h304, mem_word(32'h304), 1, 0);
`ifdef IF_ALIGN_CHECK_EN
    add(32'h102, 0, 0, 0, 0, 32'h000, 0, 32'h102, NOP, 1, 1);
    add(32'h102, 0, 0, 1, 0, 32'h000, 0, 32'h102, NOP, 1, 1);
`else
    add(32'h102, 0, 0, 0, 1, 32'h102, 1, 32'h304, NOP, 0, 0);
    add(32'h102, 0, 0, 1, 1, 32'h102, 0, 32'h102, mem_word(32'h102), 1, 0);
`endif
    add(32'h308, 0, 0, 1, 1, 32'h308, 0, 32'h308, mem_word(32'h308), 1, 0);

    // Reset state and combinational outputs before the first completion.
    do_reset();
    check_reset_values("rst");
    check("rst_addr", imem_addr_o, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pc_i = vecs[i].pc; hazard_i = vecs[i].haz; flush_i = vecs[i].fl; imem_valid_i = vecs[i].vld;
      #1;
      imem_rdata_i = mem_word(imem_addr_o);
      #1;
      check($sformatf("v%0d_req", i), {31'h0, imem_req_o}, {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].e_addr);
      check($sformatf("v%0d_stall", i), {31'h0, pc_stall_o}, {31'h0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ifid_pc", i), if_id_pc_o, vecs[i].e_pc);
      check($sformatf("v%0d_ifid_instr", i), if_id_instr_o, vecs[i].e_instr);
      check($sformatf("v%0d_ifid_valid", i), {31'h0, if_id_valid_o}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d_ifid_exc", i), {31'h0, if_id_exc_o}, {31'h0, vecs[i].e_exc});
    end

    // Asynchronous reset while parked in HOLD with a valid IF/ID entry.
    @(negedge clk);
    pc_i = 32'h400; hazard_i = 1'b1; flush_i = 1'b0; imem_valid_i = 1'b1;
    #1 imem_rdata_i = mem_word(imem_addr_o);
    @(posedge clk);
    #1;
    check("hold_req", {31'h0, imem_req_o}, 32'h0);
    check("hold_keep_pc", if_id_pc_o, 32'h308);
    @(negedge clk);
    imem_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst = 1'b0; hazard_i = 1'b0;

    // Random traffic with a PC register, random-latency memory and a program-order model.
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    busy = 0; lat = 0; cnt = 0; idle = 0; consumed = 0;
    prev_pending = 1'b0; prev_addr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      hazard_i = ($urandom_range(0, 3) == 0);
      flush_i  = ($urandom_range(0, 19) == 0);
      target   = 32'($urandom_range(0, 1023)) << 2;
      #1;
      if (imem_req_o) begin
        if (busy == 0) begin
          busy = 1; lat = $urandom_range(0, 3); cnt = 0;
        end
        imem_valid_i = (cnt == lat);
      end else begin
        imem_valid_i = 1'b0;
      end
      imem_rdata_i = mem_word(imem_addr_o);
      #1;
      if (prev_pending) begin
        check("rnd_req_held", {31'h0, imem_req_o}, 32'h1);
        check("rnd_addr_stable", imem_addr_o, prev_addr);
      end
      if (!pc_stall_o && !flush_i)
        check("rnd_stall_release", {31'h0, imem_req_o && imem_valid_i}, 32'h1);
      consume = if_id_valid_o && !hazard_i && !flush_i;
      if (consume) begin
        exp_pc = exp_q.pop_front();
        check("rnd_pc", if_id_pc_o, exp_pc);
        check("rnd_instr", if_id_instr_o, mem_word(exp_pc));
        check("rnd_exc", {31'h0, if_id_exc_o}, 32'h0);
        exp_q.push_back(exp_pc + 32'd4);
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      pre_pc = if_id_pc_o; pre_instr = if_id_instr_o; pre_valid = if_id_valid_o;
      stall_s = pc_stall_o; fl_s = flush_i; haz_s = hazard_i;
      prev_pending = imem_req_o && !imem_valid_i;
      prev_addr = imem_addr_o;
      done_mem = imem_req_o && imem_valid_i;
      @(posedge clk);
      #1;
      if (fl_s) begin
        check("rnd_flush_valid", {31'h0, if_id_valid_o}, 32'h0);
        check("rnd_flush_instr", if_id_instr_o, NOP);
        exp_q.delete();
        exp_q.push_back(target);
      end else if (haz_s) begin
        check("rnd_hold_pc", if_id_pc_o, pre_pc);
        check("rnd_hold_instr", if_id_instr_o, pre_instr);
        check("rnd_hold_valid", {31'h0, if_id_valid_o}, {31'h0, pre_valid});
      end
      if (done_mem) busy = 0;
      else if (prev_pending) cnt++;
      if (!stall_s) pc_i = fl_s ? target : pc_i + 32'd4;
      if (idle > 200) begin
        checks++; errors++;
        $display("FAIL rnd_progress_stuck act=%0d exp<=200", idle);
        break;
      end
    end
    check("rnd_consumed", {31'h0, consumed >= 300}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline. Consumes the current fetch address from the PC register and issues a request/valid transaction to instruction memory. It writes the returned instruction into the IF/ID pipeline register and drives the PC hold signal back upstream. Handles ID-stage stalls with a one-entry skid buffer, and branch/jump flushes with an in-flight response drain.

## Interface
Parameters:
- `NOP` — default 32'h0000_0013 — instruction word presented on IF/ID when invalid (ADDI x0,x0,0)

Ports:
- `clk`  in  1  — sole clock, rising edge
- `rst`  in  1  — asynchronous, active-high reset
- `pc_i`  in  32  — current fetch address from PC register
- `hazard_i`  in  1  — ID load-use stall; IF/ID must hold
- `flush_i`  in  1  — taken branch/jump; kill IF/ID and any in-flight fetch
- `pc_stall_o`  out  1  — to PC `hazardpc_i`; 1 = PC holds
- `imem_req_o`  out  1  — fetch request
- `imem_addr_o`  out  32  — fetch address, stable while `imem_req_o`=1
- `imem_valid_i`  in  1  — response valid; completes the request (may be same cycle as req)
- `imem_rdata_i`  in  32  — instruction word, sampled when req&valid
- `if_id_pc_o`  out  32  — IF/ID PC
- `if_id_instr_o`  out  32  — IF/ID instruction
- `if_id_valid_o`  out  1  — IF/ID holds a real instruction
- `if_id_exc_o`  out  1  — instruction-address-misaligned flag (see Configuration)

## Operation
- Reset values: state FETCH, `if_id_pc_o`=0, `if_id_instr_o`=NOP, `if_id_valid_o`=0, `if_id_exc_o`=0, skid empty, drain address 0.
- Combinational outputs after reset: `imem_req_o`=1, `pc_stall_o`=1 until first completion.
- FETCH:
  - `imem_req_o`=1, `imem_addr_o`=`pc_i`.
  - `pc_stall_o`=0 iff `imem_valid_i` or `flush_i`; otherwise PC holds, keeping the address stable.
  - valid, no hazard, no flush: IF/ID <= {`pc_i`, rdata, 1}.
  - valid with `hazard_i`: skid <= {`pc_i`, rdata}; IF/ID holds; go to HOLD.
  - no valid: IF/ID holds if `hazard_i`; otherwise `if_id_valid_o`<=0, instr<=NOP (bubble).
- HOLD:
  - `imem_req_o`=0, `pc_stall_o`=1, IF/ID holds while `hazard_i`.
  - When `hazard_i`=0: IF/ID <= skid, valid=1; go to FETCH.
- DRAIN:
  - `imem_req_o`=1, `imem_addr_o`=drain address (pc captured at flush), `pc_stall_o`=1 so PC keeps the branch target.
  - On `imem_valid_i`: discard rdata, go to FETCH.
- Flush (any state, priority over hazard):
  - `pc_stall_o`=0; IF/ID valid<=0, instr<=NOP; skid discarded.
  - FETCH with req outstanding and no valid this cycle: capture drain address, go to DRAIN.
  - FETCH with valid this cycle: response discarded, stay in FETCH.
  - HOLD: go to FETCH.
  - DRAIN: stay in DRAIN.
- A request is never retracted and its address never changes before `imem_valid_i`.
- `rst` mid-transaction returns to reset values immediately. Memory must tolerate request abandonment on reset.

## Timing
- Zero-wait memory (valid in same cycle as req): one instruction per clock. IF/ID updates on the edge ending the req&valid cycle; PC advances on that same edge.
- N-cycle memory: N bubbles on IF/ID per fetch; PC held N cycles.
- Stall-to-release: skid entry appears on IF/ID one edge after `hazard_i` falls. The next request starts that following cycle.
- Flush: IF/ID invalid on the next edge. The first target fetch is issued the cycle after flush from FETCH or HOLD, or the cycle after the drained response.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - In FETCH with `pc_i[1:0]`≠0, no request is issued (`imem_req_o`=0).
  - Treated as immediate completion: IF/ID <= {`pc_i`, NOP, valid=1}, `if_id_exc_o`=1, `pc_stall_o`=0.
  - Hazard and flush rules are unchanged; the exception entry uses the skid like any other.
- Undefined: `pc_i` passes to `imem_addr_o` unchanged, and `if_id_exc_o` is tied 0.

## Test plan
- Reset, zero-wait memory, PC 0,4,8, rdata=addr|0x13 -> IF/ID pc 0,4,8 on consecutive edges, valid=1, `pc_stall_o`=0.
- Memory latency 3 cycles, pc_i=0x40 -> req held 3 cycles with addr 0x40, `pc_stall_o`=1; two bubbles (valid=0, instr=NOP), then IF/ID={0x40,rdata,1}.
- `hazard_i`=1 for 2 cycles while fetch of 0x10 completes -> IF/ID unchanged, HOLD with no req; after release IF/ID pc=0x10, next req addr=0x14.
- `flush_i` one cycle after req to 0x20 (latency 3), PC target 0x100 -> req stays at 0x20 until valid, data discarded, IF/ID valid=0; then req 0x100 with `pc_stall_o`=1 throughout drain.
- Flush and hazard asserted together in HOLD -> skid dropped, IF/ID valid=0 next edge, FETCH resumes at target.
- `IF_ALIGN_CHECK_EN`, pc_i=0x102 -> no req, IF/ID={0x102,NOP,1}, `if_id_exc_o`=1; without the macro, req addr=0x102 and exc=0.
